// File: rtl/spi_mem_master_if.sv
// CPU-side request/response bundle for spi_mem_master.
// master: CPU core drives the request; slave: spi_mem_master answers it.
interface spi_mem_master_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              size;
    logic              ready;
    logic              busy;
    logic              done;
    logic [15:0]       rdata;

    modport master (
        output req, we, addr, wdata, size,
        input  ready, busy, done, rdata
    );

    modport slave (
        input  req, we, addr, wdata, size,
        output ready, busy, done, rdata
    );
endinterface

// File: rtl/spi_mem_master.sv
// SPI mode-0 initiator for a serial SRAM: turns one CPU read/write request
// into command byte + address + data, MSB first, with spi_clk = clk/2.
// Optional feature macro: SPIM_BYTE_ACCESS_EN (size = 1 selects 8-bit data).
module spi_mem_master #(
    parameter int unsigned ADDR_W    = 16,
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_mem_master_if.slave bus,
    output logic            spi_select,
    output logic            spi_clk,
    output logic            spi_mosi,
    input  logic            spi_miso
);
    localparam int unsigned SR_W  = 8 + ADDR_W + 16;
    localparam int unsigned CNT_W = $clog2(SR_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               phase_h;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   d_len;
    logic [SR_W-1:0]    tx_sr;
    logic [SR_W-1:0]    load_val;
    logic [15:0]        rx_sr;
    logic [15:0]        rdata_q;
    logic               we_q;
    logic               byte_q;
    logic               byte_sel;
    logic               active;
    logic               accept;

`ifdef SPIM_BYTE_ACCESS_EN
    assign byte_sel = bus.size;
`else
    assign byte_sel = 1'b0;
`endif

    // Shared decode: transfer activity, acceptance, and bit bookkeeping.
    always_comb begin
        active   = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
        accept   = (state_q == S_IDLE) && bus.req;
        cnt_next = bit_cnt - 1'b1;
        d_len    = byte_q ? CNT_W'(8) : CNT_W'(16);
    end

    // Transmit image: byte writes put wdata[7:0] in the top data byte so the
    // same MSB-first shift serves both widths; reads shift out zeros.
    always_comb begin
        load_val = '0;
        if (bus.we) begin
            if (byte_sel) begin
                load_val = {CMD_WRITE, bus.addr, bus.wdata[7:0], 8'h00};
            end else begin
                load_val = {CMD_WRITE, bus.addr, bus.wdata};
            end
        end else begin
            load_val = {CMD_READ, bus.addr, 16'h0000};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: segment boundaries are found from the bits remaining
    // after the current bit completes (end of its high phase).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d = S_CMD;
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (phase_h) begin
                    if (cnt_next == '0) begin
                        state_d = S_DONE;
                    end else if (cnt_next == d_len) begin
                        state_d = S_DATA;
                    end else if (cnt_next == CNT_W'(ADDR_W) + d_len) begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: load on acceptance, sample MISO at spi_clk rise, shift at fall,
    // and publish read data on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_h <= 1'b0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
        end else begin
            if (accept) begin
                phase_h <= 1'b0;
                tx_sr   <= load_val;
                rx_sr   <= '0;
                we_q    <= bus.we;
                byte_q  <= byte_sel;
                bit_cnt <= byte_sel ? CNT_W'(8 + ADDR_W + 8) : CNT_W'(SR_W);
            end else if (active) begin
                if (!phase_h) begin
                    phase_h <= 1'b1;
                    if (state_q == S_DATA && !we_q) begin
                        rx_sr <= {rx_sr[14:0], spi_miso};
                    end
                end else begin
                    phase_h <= 1'b0;
                    tx_sr   <= {tx_sr[SR_W-2:0], 1'b0};
                    bit_cnt <= cnt_next;
                    if (cnt_next == '0 && !we_q) begin
                        rdata_q <= rx_sr;
                    end
                end
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.ready  = (state_q == S_IDLE);
        bus.busy   = (state_q != S_IDLE);
        bus.done   = (state_q == S_DONE);
        bus.rdata  = rdata_q;
        spi_select = active;
        spi_clk    = active && phase_h;
        spi_mosi   = active && tx_sr[SR_W-1];
    end
endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master with a serial-SRAM pin model and a
// cycle-level expectation model of the initiator's outputs.
module tb_spi_mem_master;
    localparam int unsigned AW = 16;
`ifdef SPIM_BYTE_ACCESS_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_select;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso = 1'b1;

    spi_mem_master_if #(.ADDR_W(AW)) bus ();

    spi_mem_master #(
        .ADDR_W(AW),
        .CMD_READ(8'h03),
        .CMD_WRITE(8'h02)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .spi_select(spi_select),
        .spi_clk(spi_clk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Serial SRAM model: big-endian byte memory, sequential access.
    logic [7:0]  smem [0:65535];
    logic [7:0]  gmem [0:65535];
    int          sbit = 0;
    logic [7:0]  scmd = 8'h00;
    logic [7:0]  sbyte = 8'h00;
    logic [15:0] saddr = 16'h0000;

    always @(posedge spi_select) begin
        sbit = 0;
        spi_miso = 1'b1;
    end

    always @(posedge spi_clk) begin
        if (sbit < 8) begin
            scmd = {scmd[6:0], spi_mosi};
        end else if (sbit < 24) begin
            saddr = {saddr[14:0], spi_mosi};
        end else begin
            sbyte = {sbyte[6:0], spi_mosi};
            if (scmd == 8'h02 && (sbit - 24) % 8 == 7) begin
                smem[16'(saddr + (sbit - 24) / 8)] = sbyte;
            end
        end
        sbit++;
    end

    always @(negedge spi_clk) begin
        logic [7:0] b;
        int idx;
        if (sbit >= 24 && scmd == 8'h03) begin
            idx = sbit - 24;
            b = smem[16'(saddr + idx / 8)];
            spi_miso = b[7 - idx % 8];
        end else begin
            spi_miso = 1'b1;
        end
    end

    // Expectation model: position within a transaction (0 idle, 1..2N bit
    // phases, 2N+1 done), expected bit stream, golden memory, expected rdata.
    bit          cmp_en = 1'b0;
    int          pos = 0;
    int          nb = 40;
    logic [63:0] m_stream = '0;
    logic        m_we = 1'b0;
    logic        m_byte = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] exp_rdata = '0;

    always @(negedge clk) begin
        logic [5:0] exp_pins;
        int dl;
        if (cmp_en) begin
            if (pos == 0) begin
                exp_pins = 6'b100000;
            end else if (pos <= 2 * nb) begin
                exp_pins = {1'b0, 1'b1, 1'b0, 1'b1, (pos % 2 == 0), m_stream[nb - 1 - (pos - 1) / 2]};
            end else begin
                exp_pins = 6'b011000;
            end
            chk("pins{ready,busy,done,sel,sclk,mosi}",
                {bus.ready, bus.busy, bus.done, spi_select, spi_clk, spi_mosi}, exp_pins);
            chk("rdata", bus.rdata, exp_rdata);

            if (!rst_n) begin
                pos = 0;
                exp_rdata = '0;
            end else if (pos == 0) begin
                if (bus.req) begin
                    m_we    = bus.we;
                    m_addr  = bus.addr;
                    m_wdata = bus.wdata;
                    m_byte  = BYTE_EN && bus.size;
                    dl      = m_byte ? 8 : 16;
                    nb      = 8 + AW + dl;
                    m_stream = ({56'd0, (m_we ? 8'h02 : 8'h03)} << (AW + dl))
                             | ({48'd0, m_addr} << dl)
                             | (m_we ? (m_byte ? 64'(m_wdata[7:0]) : 64'(m_wdata)) : 64'd0);
                    pos = 1;
                end
            end else if (pos == 2 * nb + 1) begin
                pos = 0;
            end else begin
                pos++;
                if (pos == 2 * nb + 1) begin
                    if (m_we) begin
                        if (m_byte) begin
                            gmem[m_addr] = m_wdata[7:0];
                        end else begin
                            gmem[m_addr] = m_wdata[15:8];
                            gmem[16'(m_addr + 1)] = m_wdata[7:0];
                        end
                    end else begin
                        exp_rdata = m_byte ? {8'h00, gmem[m_addr]}
                                           : {gmem[m_addr], gmem[16'(m_addr + 1)]};
                    end
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] wd, input logic sz);
        int guard;
        @(posedge clk);
        #2;
        bus.req = 1'b1;
        bus.we = w;
        bus.addr = a;
        bus.wdata = wd;
        bus.size = sz;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.ready && guard < 300);
        if (!bus.ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #2;
        bus.req = 1'b0;
        bus.we = ~w;
        bus.addr = ~a;
        bus.wdata = ~wd;
        bus.size = ~sz;
    endtask

    task automatic wait_done(output int lat, output int sel_n);
        lat = 0;
        sel_n = 0;
        do begin
            @(negedge clk);
            lat++;
            if (spi_select) sel_n++;
        end while (!bus.done && lat < 300);
    endtask

    task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] wd, input logic sz,
                       output int lat, output int sel_n);
        issue(w, a, wd, sz);
        wait_done(lat, sel_n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, sel_n, cnt, guard, ndone, low, dwidth;
        logic prev_sel, prev_done, seen_high;
        for (int i = 0; i < 65536; i++) begin
            smem[i] = 8'(i) ^ 8'h5A;
            gmem[i] = 8'(i) ^ 8'h5A;
        end
        smem[16'h0010] = 8'hBE; smem[16'h0011] = 8'hEF;
        gmem[16'h0010] = 8'hBE; gmem[16'h0011] = 8'hEF;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.size = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_ready", bus.ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_select", spi_select, 0);
        chk("reset_rdata", bus.rdata, 16'h0000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (spi_select || spi_clk || spi_mosi) cnt++;
        end
        chk("idle_quiet", cnt, 0);

        txn(1'b0, 16'h0010, 16'h0000, 1'b0, lat, sel_n);
        chk("read_latency", lat, 81);
        chk("read_select_cycles", sel_n, 80);
        chk("read_rdata", bus.rdata, 16'hBEEF);
        chk("read_cmd", scmd, 8'h03);
        chk("read_addr", saddr, 16'h0010);

        txn(1'b1, 16'h0020, 16'h1234, 1'b0, lat, sel_n);
        chk("write_latency", lat, 81);
        chk("write_keeps_rdata", bus.rdata, 16'hBEEF);
        chk("write_cmd", scmd, 8'h02);
        chk("write_byte_hi", smem[16'h0020], 8'h12);
        chk("write_byte_lo", smem[16'h0021], 8'h34);

        txn(1'b0, 16'h0020, 16'h0000, 1'b0, lat, sel_n);
        chk("readback_rdata", bus.rdata, 16'h1234);

        @(posedge clk);
        #2;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0010; bus.size = 1'b0;
        ndone = 0; low = 0; dwidth = 0; guard = 0;
        prev_sel = 1'b0; prev_done = 1'b0; seen_high = 1'b0;
        while (ndone < 3 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (spi_select) begin
                if (seen_high && !prev_sel) chk("b2b_select_gap", low, 2);
                seen_high = 1'b1;
                low = 0;
            end else begin
                low++;
            end
            if (bus.done) begin
                dwidth++;
                if (!prev_done) ndone++;
            end else if (dwidth != 0) begin
                chk("b2b_done_width", dwidth, 1);
                dwidth = 0;
            end
            prev_sel = spi_select;
            prev_done = bus.done;
        end
        chk("b2b_done_count", ndone, 3);
        @(posedge clk);
        #2;
        bus.req = 1'b0;
        chk("b2b_rdata", bus.rdata, 16'hBEEF);

        issue(1'b0, 16'h0020, 16'h0000, 1'b0);
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("pre_reset_select", spi_select, 1);
        @(negedge clk);
        chk("abort_select", spi_select, 0);
        chk("abort_rdata", bus.rdata, 16'h0000);
        cnt = 0;
        repeat (3) begin
            if (bus.done) cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", cnt, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        txn(1'b0, 16'h0010, 16'h0000, 1'b0, lat, sel_n);
        chk("post_abort_latency", lat, 81);
        chk("post_abort_rdata", bus.rdata, 16'hBEEF);

`ifdef SPIM_BYTE_ACCESS_EN
        txn(1'b0, 16'h0011, 16'h0000, 1'b1, lat, sel_n);
        chk("byte_read_latency", lat, 65);
        chk("byte_read_select_cycles", sel_n, 64);
        chk("byte_read_rdata", bus.rdata, 16'h00EF);
        txn(1'b1, 16'h0040, 16'hAB5C, 1'b1, lat, sel_n);
        chk("byte_write_latency", lat, 65);
        chk("byte_write_mem", smem[16'h0040], 8'h5C);
        chk("byte_write_neighbour", smem[16'h0041], 8'h1B);
        txn(1'b0, 16'h0040, 16'h0000, 1'b1, lat, sel_n);
        chk("byte_readback", bus.rdata, 16'h005C);
`else
        txn(1'b0, 16'h0010, 16'h0000, 1'b1, lat, sel_n);
        chk("size_ignored_latency", lat, 81);
        chk("size_ignored_rdata", bus.rdata, 16'hBEEF);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
